// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode, ALU, mux encodings and FSM states for the multi-cycle controller.
package ctrl_pkg;
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_LW    = 4'h1;
    localparam logic [3:0] OP_SW    = 4'h2;
    localparam logic [3:0] OP_ADDI  = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_J     = 4'h6;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] B_RT     = 2'd0;
    localparam logic [1:0] B_TWO    = 2'd1;
    localparam logic [1:0] B_IMM    = 2'd2;
    localparam logic [1:0] B_IMM_SH = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_MEM_ADDR, S_MEM_RD, S_WB_MEM,
        S_MEM_WR, S_EXEC_I, S_WB_I, S_BRANCH, S_JUMP, S_ILLEGAL
    } state_t;

    // Only funct 0-3 are defined ALU operations for R-type.
    function automatic state_t dispatch(input logic [3:0] op, input logic [3:0] fn);
        return op == OP_RTYPE ? (fn > 4'd3 ? S_ILLEGAL : S_EXEC_R) :
               (op == OP_LW || op == OP_SW) ? S_MEM_ADDR :
               op == OP_ADDI ? S_EXEC_I :
               (op == OP_BEQ || op == OP_BNE) ? S_BRANCH :
               op == OP_J ? S_JUMP : S_ILLEGAL;
    endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive stalled memory cycles and flags when the wait limit is hit.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    output logic timeout
);
    localparam int W = MEM_TIMEOUT > 2 ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [W-1:0] LIM = W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

    logic [W-1:0] cnt_q, cnt_d;

    // Any cycle that is not a continued stall clears the count, so each access starts at zero.
    always_comb begin
        timeout = (MEM_TIMEOUT > 0) && waiting && (cnt_q == LIM);
        cnt_d   = (waiting && !timeout) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: Moore FSM sequencing a 16-bit multi-cycle datapath over a shared memory port.
module multi_cycle_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic [3:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_retired
);
    state_t state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic waiting, timeout, retire;

    assign waiting = (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR) && !mem_ready;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .waiting (waiting),
        .timeout (timeout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = dispatch(opcode, funct);
            S_EXEC_R:   state_d = S_WB_R;
            S_MEM_ADDR: state_d = opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready ? S_WB_MEM : timeout ? S_FETCH : S_MEM_RD;
            S_MEM_WR:   state_d = (mem_ready || timeout) ? S_FETCH : S_MEM_WR;
            S_EXEC_I:   state_d = S_WB_I;
            default:    state_d = S_FETCH;
        endcase
        retire = state_q == S_WB_R || state_q == S_WB_MEM || state_q == S_WB_I ||
                 state_q == S_BRANCH || state_q == S_JUMP || (state_q == S_MEM_WR && mem_ready);
        retired_d = retire ? retired_q + 1'b1 : retired_q;
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_src        = PC_ALU;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = B_RT;
        alu_op        = ALU_ADD;
        illegal_instr = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = B_TWO;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = B_IMM_SH;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = funct;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_MEM_ADDR, S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = B_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_WB_I: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pc_write  = (opcode == OP_BEQ && alu_zero) || (opcode == OP_BNE && !alu_zero);
            end
            S_JUMP: begin
                pc_src   = PC_JUMP;
                pc_write = 1'b1;
            end
            S_ILLEGAL: illegal_instr = 1'b1;
            default: ;
        endcase
        // Reset silences every strobe immediately, abandoning any in-flight access.
        if (rst) begin
            {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, mem_to_reg} = '0;
            {reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal_instr} = '0;
        end
        bus_error = timeout && !rst;
    end

    assign instr_retired = retired_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end
endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: directed per-feature checks of the multi-cycle controller.
module tb_multi_cycle_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opcode = '0, funct = '0;
    logic        alu_zero = 1'b0, mem_ready = 1'b0;
    logic        pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
    logic        reg_dst, reg_write, alu_src_a, illegal_instr, bus_error;
    logic [1:0]  pc_src, alu_src_b;
    logic [3:0]  alu_op;
    logic [15:0] instr_retired;
    int total = 0, bad = 0;
    logic [15:0] exp_ret = '0;

    multi_cycle_controller #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .illegal_instr(illegal_instr), .bus_error(bus_error),
        .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic fetch(input logic [3:0] op, input logic [3:0] fn);
        @(negedge clk);
        opcode = op; funct = fn; mem_ready = 1'b1; alu_zero = 1'b0;
        #1;
    endtask

    task automatic cyc(input logic mr, input logic z);
        @(negedge clk);
        mem_ready = mr; alu_zero = z;
        #1;
    endtask

    task automatic test_reset;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total++;
        if ({pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
             alu_src_a, alu_src_b, alu_op, illegal_instr, bus_error} !== 19'd0) begin
            bad++; $display("FAIL reset_strobes got=%0h exp=0", {pc_write, pc_src, ir_write, mem_read, mem_write});
        end
        total++;
        if (instr_retired !== 16'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", instr_retired); end
        @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
        total++;
        if ({mem_read, i_or_d, alu_src_b, ir_write} !== 5'b1_0_01_0) begin
            bad++; $display("FAIL reset_fetch got=%b exp=10010", {mem_read, i_or_d, alu_src_b, ir_write});
        end
    endtask

    task automatic test_add;
        fetch(4'h0, 4'h0);
        total++;
        if ({ir_write, pc_write} !== 2'b11) begin bad++; $display("FAIL add_c0_irw got=%b exp=11", {ir_write, pc_write}); end
        cyc(1'b0, 1'b0);
        total++;
        if (alu_src_b !== 2'd3) begin bad++; $display("FAIL add_decode_srcb got=%0d exp=3", alu_src_b); end
        cyc(1'b0, 1'b0);
        total++;
        if ({alu_op, alu_src_a, alu_src_b} !== {4'd0, 1'b1, 2'd0}) begin
            bad++; $display("FAIL add_exec got=%b exp=0000100", {alu_op, alu_src_a, alu_src_b});
        end
        cyc(1'b0, 1'b0);
        total++;
        if ({reg_write, reg_dst, mem_to_reg} !== 3'b110) begin
            bad++; $display("FAIL add_wb got=%b exp=110", {reg_write, reg_dst, mem_to_reg});
        end
        exp_ret++;
        cyc(1'b0, 1'b0);
        total++;
        if (instr_retired !== exp_ret) begin bad++; $display("FAIL add_retired got=%0d exp=%0d", instr_retired, exp_ret); end
    endtask

    task automatic test_addi;
        fetch(4'h3, 4'h7);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        total++;
        if ({alu_src_a, alu_src_b, alu_op} !== {1'b1, 2'd2, 4'd0}) begin
            bad++; $display("FAIL addi_exec got=%b exp=1100000", {alu_src_a, alu_src_b, alu_op});
        end
        cyc(1'b0, 1'b0);
        total++;
        if ({reg_write, reg_dst, mem_to_reg} !== 3'b100) begin
            bad++; $display("FAIL addi_wb got=%b exp=100", {reg_write, reg_dst, mem_to_reg});
        end
        exp_ret++;
        cyc(1'b0, 1'b0);
        total++;
        if (instr_retired !== exp_ret) begin bad++; $display("FAIL addi_retired got=%0d exp=%0d", instr_retired, exp_ret); end
    endtask

    task automatic test_lw_stall;
        fetch(4'h1, 4'h0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        total++;
        if ({alu_src_a, alu_src_b} !== 3'b110) begin bad++; $display("FAIL lw_addr got=%b exp=110", {alu_src_a, alu_src_b}); end
        for (int k = 0; k < 4; k++) begin
            cyc(k == 3, 1'b0);
            total++;
            if ({mem_read, i_or_d, reg_write} !== 3'b110) begin
                bad++; $display("FAIL lw_memrd_%0d got=%b exp=110", k, {mem_read, i_or_d, reg_write});
            end
        end
        cyc(1'b0, 1'b0);
        total++;
        if ({mem_to_reg, reg_write, reg_dst, mem_read} !== 4'b1100) begin
            bad++; $display("FAIL lw_wb got=%b exp=1100", {mem_to_reg, reg_write, reg_dst, mem_read});
        end
        exp_ret++;
        cyc(1'b0, 1'b0);
        total++;
        if (instr_retired !== exp_ret) begin bad++; $display("FAIL lw_retired got=%0d exp=%0d", instr_retired, exp_ret); end
    endtask

    task automatic test_branch;
        fetch(4'h4, 4'h0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        total++;
        if ({pc_write, pc_src, alu_op, alu_src_a} !== {1'b1, 2'd1, 4'd1, 1'b1}) begin
            bad++; $display("FAIL beq_taken got=%b exp=10100011", {pc_write, pc_src, alu_op, alu_src_a});
        end
        exp_ret++;
        fetch(4'h5, 4'h0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        total++;
        if ({pc_write, reg_write} !== 2'b00) begin bad++; $display("FAIL bne_zero got=%b exp=00", {pc_write, reg_write}); end
        exp_ret++;
        cyc(1'b0, 1'b0);
        total++;
        if (instr_retired !== exp_ret) begin bad++; $display("FAIL br_retired got=%0d exp=%0d", instr_retired, exp_ret); end
    endtask

    task automatic test_illegal;
        fetch(4'h9, 4'h0);
        cyc(1'b0, 1'b0);
        total++;
        if (illegal_instr !== 1'b0) begin bad++; $display("FAIL ill_decode got=%b exp=0", illegal_instr); end
        cyc(1'b0, 1'b0);
        total++;
        if ({illegal_instr, reg_write, pc_write} !== 3'b100) begin
            bad++; $display("FAIL ill_pulse got=%b exp=100", {illegal_instr, reg_write, pc_write});
        end
        cyc(1'b0, 1'b0);
        total++;
        if ({illegal_instr, mem_read} !== 2'b01) begin bad++; $display("FAIL ill_after got=%b exp=01", {illegal_instr, mem_read}); end
        total++;
        if (instr_retired !== exp_ret) begin bad++; $display("FAIL ill_retired got=%0d exp=%0d", instr_retired, exp_ret); end
        fetch(4'h0, 4'h5);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        total++;
        if ({illegal_instr, alu_src_a} !== 2'b10) begin bad++; $display("FAIL ill_funct got=%b exp=10", {illegal_instr, alu_src_a}); end
        cyc(1'b0, 1'b0);
        total++;
        if (instr_retired !== exp_ret) begin bad++; $display("FAIL illf_retired got=%0d exp=%0d", instr_retired, exp_ret); end
    endtask

    task automatic test_timeout;
        fetch(4'h6, 4'h0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        total++;
        if ({pc_write, pc_src} !== 3'b110) begin bad++; $display("FAIL jump got=%b exp=110", {pc_write, pc_src}); end
        exp_ret++;
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b0);
            total++;
            if ({bus_error, mem_read} !== {k == 15, 1'b1}) begin
                bad++; $display("FAIL tmo_cycle_%0d got=%b exp=%b", k, {bus_error, mem_read}, {k == 15, 1'b1});
            end
        end
        total++;
        if (instr_retired !== exp_ret) begin bad++; $display("FAIL tmo_retired got=%0d exp=%0d", instr_retired, exp_ret); end
    endtask

    task automatic test_sw_reset;
        fetch(4'h2, 4'h0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        total++;
        if ({mem_write, i_or_d, mem_read} !== 3'b110) begin
            bad++; $display("FAIL sw_memwr got=%b exp=110", {mem_write, i_or_d, mem_read});
        end
        @(negedge clk); rst = 1'b1; #1;
        total++;
        if (mem_write !== 1'b0) begin bad++; $display("FAIL sw_rst_drop got=%b exp=0", mem_write); end
        exp_ret = '0;
        @(negedge clk); rst = 1'b0; #1;
        total++;
        if ({mem_write, mem_read, i_or_d} !== 3'b010) begin
            bad++; $display("FAIL sw_after_rst got=%b exp=010", {mem_write, mem_read, i_or_d});
        end
        total++;
        if (instr_retired !== exp_ret) begin bad++; $display("FAIL sw_rst_retired got=%0d exp=%0d", instr_retired, exp_ret); end
        cyc(1'b1, 1'b0);
        total++;
        if (mem_write !== 1'b0) begin bad++; $display("FAIL sw_no_write got=%b exp=0", mem_write); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_addi;
        test_lw_stall;
        test_branch;
        test_illegal;
        test_timeout;
        test_sw_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
